// File: rtl/mem_arbiter2.sv
// Two-master memory arbiter: round-robin grant into a registered request slot,
// in-order read responses steered back to the issuer through a 1-bit tag FIFO.
module mem_arbiter2 #(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req0_m_address,
  input  logic [31:0] req0_m_data,
  input  logic        req0_m_write,
  input  logic        req0_m_valid,
  output logic        req0_m_ready,
  output logic [31:0] req0_s_data,
  output logic        req0_s_valid,
  input  logic        req0_s_ready,
  input  logic [31:0] req1_m_address,
  input  logic [31:0] req1_m_data,
  input  logic        req1_m_write,
  input  logic        req1_m_valid,
  output logic        req1_m_ready,
  output logic [31:0] req1_s_data,
  output logic        req1_s_valid,
  input  logic        req1_s_ready,
  output logic [31:0] mem_m_address,
  output logic [31:0] mem_m_data,
  output logic        mem_m_write,
  output logic        mem_m_valid,
  input  logic        mem_m_ready,
  input  logic [31:0] mem_s_data,
  input  logic        mem_s_valid,
  output logic        mem_s_ready
);

  localparam int PW = $clog2(OUTSTANDING);
  localparam logic [PW:0] MAX_CNT = (PW+1)'(OUTSTANDING);

  logic        slot_vld_q, slot_vld_d;
  logic [31:0] slot_addr_q, slot_addr_d;
  logic [31:0] slot_data_q, slot_data_d;
  logic        slot_wr_q, slot_wr_d;
  logic        last_q, last_d;
  logic        tag_q [OUTSTANDING];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;

  logic empty, head, pop, push, room, slot_free;
  logic elig0, elig1, gnt, win, win_wr;

  assign empty       = (cnt_q == '0);
  assign head        = tag_q[rd_ptr_q];
  assign mem_s_ready = !empty && (head ? req1_s_ready : req0_s_ready);
  assign pop         = mem_s_valid && mem_s_ready;
  // A pop this cycle frees a tag entry for a load granted in the same cycle.
  assign room        = (cnt_q != MAX_CNT) || pop;
  assign slot_free   = !slot_vld_q || mem_m_ready;
  assign elig0       = req0_m_valid && (req0_m_write || room);
  assign elig1       = req1_m_valid && (req1_m_write || room);
  assign gnt         = slot_free && (elig0 || elig1);
  assign win         = (elig0 && elig1) ? !last_q : elig1;
  assign win_wr      = win ? req1_m_write : req0_m_write;
  assign push        = gnt && !win_wr;

  assign req0_m_ready  = gnt && !win;
  assign req1_m_ready  = gnt && win;
  assign req0_s_valid  = mem_s_valid && !empty && !head;
  assign req1_s_valid  = mem_s_valid && !empty && head;
  assign req0_s_data   = mem_s_data;
  assign req1_s_data   = mem_s_data;
  assign mem_m_valid   = slot_vld_q;
  assign mem_m_address = slot_addr_q;
  assign mem_m_data    = slot_data_q;
  assign mem_m_write   = slot_wr_q;

  always_comb begin
    slot_vld_d  = slot_vld_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    slot_wr_d   = slot_wr_q;
    last_d      = last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    if (gnt) begin
      slot_vld_d  = 1'b1;
      slot_addr_d = win ? req1_m_address : req0_m_address;
      slot_data_d = win ? req1_m_data : req0_m_data;
      slot_wr_d   = win_wr;
      last_d      = win;
    end else if (mem_m_ready) begin
      slot_vld_d = 1'b0;
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_vld_q <= 1'b0;
      last_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Payload and tag storage are qualified by valid/count, so they need no reset.
  always_ff @(posedge clk) begin
    slot_addr_q <= slot_addr_d;
    slot_data_q <= slot_data_d;
    slot_wr_q   <= slot_wr_d;
    if (push) tag_q[wr_ptr_q] <= win;
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed scenarios followed by randomized traffic checked against a queue-based model.
module tb_mem_arbiter2;
  localparam int OUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] a0, d0, a1, d1, ma, md, msd, sd0, sd1;
  logic        w0, v0, w1, v1, rdy0, rdy1, sv0, sv1, sr0, sr1;
  logic        mw, mv, mr, msv, msr;

  int checks = 0;
  int errors = 0;

  mem_arbiter2 #(.OUTSTANDING(OUT)) dut (
    .clk(clk), .reset(reset),
    .req0_m_address(a0), .req0_m_data(d0), .req0_m_write(w0), .req0_m_valid(v0),
    .req0_m_ready(rdy0), .req0_s_data(sd0), .req0_s_valid(sv0), .req0_s_ready(sr0),
    .req1_m_address(a1), .req1_m_data(d1), .req1_m_write(w1), .req1_m_valid(v1),
    .req1_m_ready(rdy1), .req1_s_data(sd1), .req1_s_valid(sv1), .req1_s_ready(sr1),
    .mem_m_address(ma), .mem_m_data(md), .mem_m_write(mw), .mem_m_valid(mv),
    .mem_m_ready(mr), .mem_s_data(msd), .mem_s_valid(msv), .mem_s_ready(msr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v0 = 0; w0 = 0; a0 = '0; d0 = '0;
    v1 = 0; w1 = 0; a1 = '0; d1 = '0;
    sr0 = 1; sr1 = 1; mr = 1; msv = 0; msd = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  // Reference model state
  int          tagq[$];
  bit          m_vld, m_wr;
  logic [31:0] m_addr, m_data;
  int          m_last;
  int          ds_reads;
  bit          rsp_vld;
  logic [31:0] rsp_dat;
  bit          pv[2], pw[2], el[2], srr[2];
  logic [31:0] pa[2], pd[2];
  bit          e_empty, e_msr, e_pop, e_room, e_free, e_gnt;
  int          hd, e_win;

  initial begin
    reset = 1;
    idle();

    // Reset state
    do_reset();
    #1;
    check("rst_mem_valid", mv, 0);
    check("rst_req0_ready", rdy0, 0);
    check("rst_req1_ready", rdy1, 0);
    msv = 1;
    #1;
    check("empty_mem_s_ready", msr, 0);
    check("empty_s_valid0", sv0, 0);
    check("empty_s_valid1", sv1, 0);
    msv = 0;

    // Single load from req0
    v0 = 1; a0 = 32'h100; w0 = 0;
    #1;
    check("t1_req0_ready", rdy0, 1);
    tick();
    v0 = 0;
    #1;
    check("t1_mem_valid", mv, 1);
    check("t1_mem_addr", ma, 32'h100);
    check("t1_mem_write", mw, 0);
    tick();
    check("t1_slot_clear", mv, 0);
    msv = 1; msd = 32'hDEADBEEF;
    #1;
    check("t1_s_valid0", sv0, 1);
    check("t1_s_valid1", sv1, 0);
    check("t1_s_data0", sd0, 32'hDEADBEEF);
    check("t1_mem_s_ready", msr, 1);
    tick();
    msv = 0;

    // Continuous contention alternates
    do_reset();
    v0 = 1; a0 = 32'h0; w0 = 0;
    v1 = 1; a1 = 32'h4; d1 = 32'hAA; w1 = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("alt_req0_ready", rdy0, (i % 2 == 0) ? 1 : 0);
      check("alt_req1_ready", rdy1, (i % 2 == 1) ? 1 : 0);
      tick();
      check("alt_mem_valid", mv, 1);
      check("alt_mem_write", mw, (i % 2 == 1) ? 1 : 0);
      check("alt_mem_addr", ma, (i % 2 == 1) ? 32'h4 : 32'h0);
    end

    // Downstream stall holds the slot
    mr = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_req0_ready", rdy0, 0);
      check("stall_req1_ready", rdy1, 0);
      check("stall_mem_addr", ma, 32'h4);
      check("stall_mem_data", md, 32'hAA);
      tick();
    end
    mr = 1;
    #1;
    check("resume_req0_ready", rdy0, 1);
    check("resume_req1_ready", rdy1, 0);
    tick();
    v0 = 0; v1 = 0;
    #1;
    check("resume_mem_addr", ma, 32'h0);
    check("resume_mem_write", mw, 0);
    tick();

    // Full tag FIFO: loads stall, stores proceed
    do_reset();
    v1 = 1; w1 = 0;
    for (int k = 0; k < 4; k++) begin
      a1 = 32'h10 + 32'(4 * k);
      #1;
      check("fill_req1_ready", rdy1, 1);
      tick();
    end
    a1 = 32'h20;
    v0 = 1; w0 = 1; a0 = 32'h8; d0 = 32'h77;
    #1;
    check("full_req1_ready", rdy1, 0);
    check("full_store_ready", rdy0, 1);
    tick();
    v0 = 0;
    #1;
    check("full_store_addr", ma, 32'h8);
    check("full_store_write", mw, 1);
    check("full_req1_still", rdy1, 0);
    tick();
    msv = 1; msd = 32'h55;
    #1;
    check("pop_mem_s_ready", msr, 1);
    check("pop_s_valid1", sv1, 1);
    check("pop_req1_ready", rdy1, 1);
    tick();
    msv = 0; v1 = 0;
    #1;
    check("pop_mem_addr", ma, 32'h20);
    tick();

    // In-order response steering
    do_reset();
    v0 = 1; a0 = 32'h30; w0 = 0;
    #1;
    check("io_g0", rdy0, 1);
    tick();
    v0 = 0; v1 = 1; a1 = 32'h34; w1 = 0;
    #1;
    check("io_g1", rdy1, 1);
    tick();
    v1 = 0; v0 = 1; a0 = 32'h38;
    #1;
    check("io_g2", rdy0, 1);
    tick();
    v0 = 0;
    tick();
    msv = 1; msd = 32'h1;
    #1;
    check("io_r0_valid0", sv0, 1);
    check("io_r0_valid1", sv1, 0);
    check("io_r0_data", sd0, 32'h1);
    tick();
    msd = 32'h2; sr1 = 0;
    #1;
    check("io_r1_valid1", sv1, 1);
    check("io_r1_valid0", sv0, 0);
    check("io_r1_held", msr, 0);
    tick();
    check("io_r1_held2", msr, 0);
    check("io_r1_data", sd1, 32'h2);
    sr1 = 1;
    #1;
    check("io_r1_release", msr, 1);
    tick();
    msd = 32'h3;
    #1;
    check("io_r2_valid0", sv0, 1);
    check("io_r2_data", sd0, 32'h3);
    tick();
    msv = 0;

    // Reset mid-transaction
    do_reset();
    v0 = 1; a0 = 32'h40; w0 = 0;
    tick();
    v0 = 0; v1 = 1; a1 = 32'h44; w1 = 0;
    tick();
    v1 = 0; mr = 0; reset = 1;
    tick();
    reset = 0;
    #1;
    check("mrst_mem_valid", mv, 0);
    msv = 1;
    #1;
    check("mrst_mem_s_ready", msr, 0);
    check("mrst_s_valid0", sv0, 0);
    check("mrst_s_valid1", sv1, 0);
    msv = 0; mr = 1;
    v0 = 1; v1 = 1; w0 = 0; w1 = 0;
    #1;
    check("mrst_req0_wins", rdy0, 1);
    check("mrst_req1_loses", rdy1, 0);
    tick();

    // Randomized traffic against the model
    do_reset();
    tagq.delete();
    m_vld = 0; m_wr = 0; m_addr = '0; m_data = '0; m_last = 1;
    ds_reads = 0; rsp_vld = 0; rsp_dat = '0;
    pv[0] = 0; pv[1] = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pv[n] && $urandom_range(0, 2) != 0) begin
          pv[n] = 1;
          pa[n] = $urandom;
          pd[n] = $urandom;
          pw[n] = 1'($urandom_range(0, 1));
        end
        srr[n] = ($urandom_range(0, 3) != 0);
      end
      mr = ($urandom_range(0, 3) != 0);
      if (!rsp_vld && ds_reads > 0 && $urandom_range(0, 1) == 1) begin
        rsp_vld = 1;
        rsp_dat = $urandom;
      end
      v0 = pv[0]; a0 = pa[0]; d0 = pd[0]; w0 = pw[0]; sr0 = srr[0];
      v1 = pv[1]; a1 = pa[1]; d1 = pd[1]; w1 = pw[1]; sr1 = srr[1];
      msv = rsp_vld; msd = rsp_dat;
      #1;
      e_empty = (tagq.size() == 0);
      hd      = e_empty ? 0 : tagq[0];
      e_msr   = !e_empty && srr[hd];
      e_pop   = rsp_vld && e_msr;
      e_room  = (tagq.size() - int'(e_pop)) < OUT;
      e_free  = !m_vld || mr;
      for (int n = 0; n < 2; n++) el[n] = pv[n] && (pw[n] || e_room);
      e_gnt   = e_free && (el[0] || el[1]);
      e_win   = (el[0] && el[1]) ? 1 - m_last : (el[1] ? 1 : 0);
      check("rnd_req0_ready", rdy0, (e_gnt && e_win == 0) ? 1 : 0);
      check("rnd_req1_ready", rdy1, (e_gnt && e_win == 1) ? 1 : 0);
      check("rnd_mem_s_ready", msr, e_msr);
      check("rnd_s_valid0", sv0, (rsp_vld && !e_empty && hd == 0) ? 1 : 0);
      check("rnd_s_valid1", sv1, (rsp_vld && !e_empty && hd == 1) ? 1 : 0);
      check("rnd_mem_valid", mv, m_vld);
      if (rsp_vld) check("rnd_s_data", (hd == 1) ? sd1 : sd0, rsp_dat);
      if (m_vld) begin
        check("rnd_mem_addr", ma, m_addr);
        check("rnd_mem_data", md, m_data);
        check("rnd_mem_write", mw, m_wr);
      end
      if (e_pop) begin
        void'(tagq.pop_front());
        ds_reads--;
        rsp_vld = 0;
      end
      if (m_vld && mr && !m_wr) ds_reads++;
      if (e_gnt) begin
        m_vld  = 1;
        m_addr = pa[e_win];
        m_data = pd[e_win];
        m_wr   = pw[e_win];
        m_last = e_win;
        if (!pw[e_win]) tagq.push_back(e_win);
        pv[e_win] = 0;
      end else if (mr) begin
        m_vld = 0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
